// File: rtl/quad_step_decoder_if.sv
// quad_step_decoder_if: encoder inputs, load bus and decoded step/count outputs of quad_step_decoder
// Ports (master drives, slave is the decoder):
//   enc_a, enc_b  raw encoder phases, asynchronous to clk
//   load, data_in count load strobe and value
//   step, dir     one-cycle step pulse and direction of the last legal step
//   count         WIDTH-bit position count
//   carry, borrow one-cycle wrap pulses of count
//   err           one-cycle pulse when both phases changed together
interface quad_step_decoder_if #(parameter int WIDTH = 8);
  logic enc_a, enc_b, load;
  logic [WIDTH-1:0] data_in;
  logic step, dir, carry, borrow, err;
  logic [WIDTH-1:0] count;
  modport master (
    output enc_a, enc_b, load, data_in,
    input  step, dir, count, carry, borrow, err
  );
  modport slave (
    input  enc_a, enc_b, load, data_in,
    output step, dir, count, carry, borrow, err
  );
endinterface

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: synchronises and glitch-filters a quadrature encoder and drives a loadable position count
// Ports:
//   clk    system clock, all state on rising edge
//   reset  asynchronous active-low reset, clears all state
//   bus    quad_step_decoder_if.slave: enc_a/enc_b/load/data_in in; step/dir/count/carry/borrow/err out
module quad_step_decoder #(
  parameter int WIDTH    = 8,
  parameter int FILT_LEN = 3
) (
  input logic            clk,
  input logic            reset,
  quad_step_decoder_if.slave bus
);
  typedef enum logic [1:0] {FLUSH0, FLUSH1, IDLE, ARMED} arm_t;
  arm_t state, state_nx;
  logic [1:0] s1, s2, filt, prev, delta;
  logic [1:0][3:0] fcnt;
  logic settled, up, dn, bad;
  logic step_q, dir_q, carry_q, borrow_q, err_q;
  logic [WIDTH-1:0] count_q;

  // bit 1 carries phase A, bit 0 phase B
  always_ff @(posedge clk or negedge reset)
    if (!reset) {s2, s1} <= '0;
    else {s2, s1} <= {s1, bus.enc_a, bus.enc_b};

  // a phase only follows its synced value after FILT_LEN consecutive differing cycles
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      filt <= '0;
      fcnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (s2[i] == filt[i]) fcnt[i] <= '0;
        else if (fcnt[i] == 4'(FILT_LEN - 1)) begin
          filt[i] <= s2[i];
          fcnt[i] <= '0;
        end else fcnt[i] <= fcnt[i] + 4'd1;
    end

  assign settled = fcnt == '0 && filt == s2;

  // Gray position 00->0, 01->1, 11->2, 10->3; a wrap-around difference of 1 is up, 3 down, 2 illegal
  assign delta = {filt[1], ^filt} - {prev[1], ^prev};

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FLUSH0;
    else state <= state_nx;

  // the flush states let the reset-cleared sync chain fill with the real encoder level before
  // the settled check, so a level already present at reset release arms instead of decoding
  always_comb begin
    state_nx = state;
    up = 1'b0;
    dn = 1'b0;
    bad = 1'b0;
    case (state)
      FLUSH0: state_nx = FLUSH1;
      FLUSH1: state_nx = IDLE;
      IDLE:   state_nx = settled ? ARMED : IDLE;
      ARMED: begin
        up  = delta == 2'd1;
        dn  = delta == 2'd3;
        bad = delta == 2'd2;
      end
      default: state_nx = FLUSH0;
    endcase
  end

  // prev follows filt every cycle, so while disarmed it simply tracks the filtered level
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      prev <= '0;
      step_q <= 1'b0;
      dir_q <= 1'b0;
      carry_q <= 1'b0;
      borrow_q <= 1'b0;
      err_q <= 1'b0;
      count_q <= '0;
    end else begin
      prev <= filt;
      step_q <= up | dn;
      err_q <= bad;
      dir_q <= up | dn ? up : dir_q;
      carry_q <= !bus.load && up && &count_q;
      borrow_q <= !bus.load && dn && ~|count_q;
      count_q <= bus.load ? bus.data_in : up ? count_q + WIDTH'(1) : dn ? count_q - WIDTH'(1) : count_q;
    end

  assign bus.step = step_q;
  assign bus.dir = dir_q;
  assign bus.carry = carry_q;
  assign bus.borrow = borrow_q;
  assign bus.err = err_q;
  assign bus.count = count_q;
endmodule
